lock_input_ctrl: RTL and testbench
==================================

Name: lock_input_ctrl

Overview:
- Front-end controller between the raw board pushbuttons and the lock state machine.
- Synchronises and debounces btn_enter, btn_clr and btn_change, then issues single-cycle command pulses, at most one per cycle, using fixed-priority arbitration.
- Tracks consecutive failed unlock attempts reported by the lock FSM. After MAX_FAIL failures it imposes a timed lockout that suppresses enter and change commands.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a new debounced level is accepted (>=2).
- MAX_FAIL, 3: consecutive failures that trigger lockout (1..7).
- LOCKOUT_CYCLES, 50000000: lockout duration in clk cycles (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- btn_enter  in  1  raw enter button, asynchronous to clk
- btn_clr  in  1  raw clear button, asynchronous
- btn_change  in  1  raw change button, asynchronous
- attempt_done  in  1  one-cycle pulse from the lock FSM when a password check completes
- attempt_ok  in  1  qualifies attempt_done: 1 = password matched
- enter_p  out  1  one-cycle enter command
- clr_p  out  1  one-cycle clear command
- change_p  out  1  one-cycle change command
- locked_out  out  1  high while lockout is active
- fail_count  out  3  current consecutive-failure count

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - all outputs 0;
  - synchronisers, debounced levels, debounce counters and pending flags 0;
  - state NORMAL, timer 0.
- Synchroniser: two flops per button.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the debounced level. It clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, the debounced level toggles and the counter clears.
- Edge detect: a rising edge of a debounced level sets that button's pending flag. Falling edges are ignored.
- Arbiter, one grant per cycle:
  - Priority is clr > enter > change.
  - The granted flag clears and its output pulses high for exactly one cycle on the next clk edge (outputs are registered).
  - Ungranted flags remain pending.
  - If a set and a clear of the same flag fall in the same cycle, the set wins.
- Latency: raw input held stable high → pulse asserted exactly DEBOUNCE_CYCLES+3 cycles after the first sampling edge, provided no higher-priority flag is pending.
- Lockout state machine, states NORMAL and LOCKED:
  - NORMAL, attempt_done & attempt_ok: fail_count ← 0.
  - NORMAL, attempt_done & !attempt_ok: fail_count ← fail_count+1.
  - NORMAL, when that increment makes fail_count == MAX_FAIL:
    - next state LOCKED;
    - timer ← LOCKOUT_CYCLES-1;
    - locked_out ← 1 in the same edge.
  - LOCKED, each cycle: timer decrements.
  - LOCKED, while locked:
    - enter and change pending flags are discarded without a pulse, and enter_p and change_p stay 0;
    - clr is still arbitrated and pulsed normally;
    - attempt_done is ignored;
    - fail_count holds MAX_FAIL.
  - LOCKED, timer == 0: next state NORMAL, fail_count ← 0, locked_out ← 0.
  - Lockout length: locked_out is high for exactly LOCKOUT_CYCLES cycles.
- Reset asserted mid-lockout or mid-debounce aborts immediately to the reset values listed above.
- A press already pending when lockout begins is discarded (enter and change flags only).

Optional Feature:
- Macro LOCK_INPUT_ESCALATE_EN.
- Defined:
  - A 2-bit lockout counter n increments (saturating at 3) on each entry into LOCKED.
  - Lockout duration is LOCKOUT_CYCLES << n, where n is the value before the increment: 1x, 2x, 4x, then 8x.
  - n clears on a successful attempt (attempt_done & attempt_ok) and on reset.
- Undefined: the counter is absent and every lockout lasts LOCKOUT_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, MAX_FAIL=3, LOCKOUT_CYCLES=10):
- Debounce and latency:
  - Bounce btn_enter 1/0 every cycle for 6 cycles, then hold high for 12 cycles → exactly one enter_p, 7 cycles after the stable-high start.
  - Release and press again → a second enter_p.
- Arbitration: press btn_clr, btn_enter and btn_change in the same cycle, held → clr_p at cycle 7, enter_p at 8, change_p at 9, each one cycle wide, never overlapping.
- Failure counting: three attempt_done pulses with attempt_ok=0 → fail_count 1, 2, 3.
  - locked_out rises on the edge of the third pulse and stays high for 10 cycles.
  - fail_count is 0 after lockout ends.
- Lockout masking:
  - During lockout, press enter and change → no enter_p or change_p.
  - During lockout, press clr → clr_p still issued.
  - After lockout, press enter → enter_p.
- Success clears: two fails, then attempt_done with attempt_ok=1 → fail_count 0; a further two fails do not lock out.
- Reset mid-lockout: assert rst at lockout cycle 4 → locked_out=0 and fail_count=0 immediately.
  - With LOCK_INPUT_ESCALATE_EN defined: the second consecutive lockout lasts 20 cycles and the third lasts 40.

Source files
------------

// File: rtl/lock_input_ctrl.sv
// Button front end: sync, debounce, priority command pulses, failed-attempt lockout.
// Define LOCK_INPUT_ESCALATE_EN to double each consecutive lockout, up to 8x.
module lock_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_FAIL        = 3,
   parameter int LOCKOUT_CYCLES  = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_enter,
   input  logic       btn_clr,
   input  logic       btn_change,
   input  logic       attempt_done,
   input  logic       attempt_ok,
   output logic       enter_p,
   output logic       clr_p,
   output logic       change_p,
   output logic       locked_out,
   output logic [2:0] fail_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
`ifdef LOCK_INPUT_ESCALATE_EN
   localparam int TW = $clog2(LOCKOUT_CYCLES + 1) + 3;
`else
   localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
`endif
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]    FAIL_MAX = 3'(MAX_FAIL);

   typedef enum logic {NORMAL, LOCKED} state_t;

   state_t        state, state_n;
   logic [2:0]    btn, sync1, sync2, deb, deb_d;
   logic [2:0]    rise, pend, pend_n, grant;
   logic [CW-1:0] cnt [3];
   logic [2:0]    fail_n;
   logic [TW-1:0] timer, timer_n, lock_len;
   logic          lock_now, mask;

   // bit 0 = clr, 1 = enter, 2 = change; lower index wins arbitration
   assign btn  = {btn_change, btn_enter, btn_clr};
   assign rise = deb & ~deb_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= ~deb[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

`ifdef LOCK_INPUT_ESCALATE_EN
   logic [1:0] esc, esc_n;

   assign lock_len = TW'(LOCKOUT_CYCLES) << esc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) esc <= '0;
      else     esc <= esc_n;
   end
`else
   assign lock_len = TW'(LOCKOUT_CYCLES);
`endif

   always_comb begin
      state_n  = state;
      fail_n   = fail_count;
      timer_n  = timer;
      lock_now = 1'b0;
`ifdef LOCK_INPUT_ESCALATE_EN
      esc_n    = esc;
`endif
      case (state)
         NORMAL: begin
            if (attempt_done) begin
               if (attempt_ok) begin
                  fail_n = '0;
`ifdef LOCK_INPUT_ESCALATE_EN
                  esc_n  = '0;
`endif
               end else begin
                  fail_n = fail_count + 3'd1;
                  if (fail_n == FAIL_MAX) begin
                     state_n  = LOCKED;
                     timer_n  = lock_len - TW'(1);
                     lock_now = 1'b1;
`ifdef LOCK_INPUT_ESCALATE_EN
                     esc_n    = (esc == 2'd3) ? esc : esc + 2'd1;
`endif
                  end
               end
            end
         end
         LOCKED: begin
            if (timer == '0) begin
               state_n = NORMAL;
               fail_n  = '0;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
      endcase
   end

   // enter/change are dropped from the very edge that starts a lockout
   assign mask = (state == LOCKED) | lock_now;

   always_comb begin
      grant = '0;
      if (pend[0])               grant[0] = 1'b1;
      else if (pend[1] && !mask) grant[1] = 1'b1;
      else if (pend[2] && !mask) grant[2] = 1'b1;
      pend_n = (pend & ~grant) | rise;
      if (mask) pend_n[2:1] = 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= NORMAL;
         timer      <= '0;
         fail_count <= '0;
         locked_out <= 1'b0;
         pend       <= '0;
         clr_p      <= 1'b0;
         enter_p    <= 1'b0;
         change_p   <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         fail_count <= fail_n;
         locked_out <= (state_n == LOCKED);
         pend       <= pend_n;
         clr_p      <= grant[0];
         enter_p    <= grant[1];
         change_p   <= grant[2];
      end
   end

endmodule

// File: tb/tb_lock_input_ctrl.sv
// Bench for lock_input_ctrl: directed tables/sequences plus random stimulus
// against a window-based behavioural model of debounce, arbitration and lockout.
module tb_lock_input_ctrl;

   localparam int D  = 4;
   localparam int MF = 3;
   localparam int LC = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_enter = 1'b0;
   logic       btn_clr = 1'b0;
   logic       btn_change = 1'b0;
   logic       attempt_done = 1'b0;
   logic       attempt_ok = 1'b0;
   logic       enter_p, clr_p, change_p, locked_out;
   logic [2:0] fail_count;

   int total = 0;
   int bad   = 0;
   bit scb_on = 1'b0;

   typedef struct {
      logic       done;
      logic       ok;
      logic       lo;
      logic [2:0] fc;
   } vec_t;
   vec_t tbl [20];

   // reference model state
   logic [2:0] raw_hist [$];
   logic [2:0] m_deb, m_setq, m_pend, m_out;
   int         m_fails, m_left, m_n;

   always #5 clk = ~clk;

   lock_input_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .MAX_FAIL(MF),
      .LOCKOUT_CYCLES(LC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_enter(btn_enter),
      .btn_clr(btn_clr),
      .btn_change(btn_change),
      .attempt_done(attempt_done),
      .attempt_ok(attempt_ok),
      .enter_p(enter_p),
      .clr_p(clr_p),
      .change_p(change_p),
      .locked_out(locked_out),
      .fail_count(fail_count)
   );

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      raw_hist.delete();
      repeat (D + 2) raw_hist.push_front(3'b000);
      m_deb   = '0;
      m_setq  = '0;
      m_pend  = '0;
      m_out   = '0;
      m_fails = 0;
      m_left  = 0;
      m_n     = 0;
   endtask

   // A level is accepted once the last D synchronised samples (raw delayed
   // by two edges) all disagree with the current debounced level.
   task automatic model_edge();
      logic [2:0] raw, grant;
      bit locked, locking, mask, diff;
      raw = {btn_change, btn_enter, btn_clr};
      raw_hist.push_front(raw);
      void'(raw_hist.pop_back());
      locked  = (m_left > 0);
      locking = 1'b0;
      if (!locked) begin
         if (attempt_done) begin
            if (attempt_ok) begin
               m_fails = 0;
               m_n     = 0;
            end else begin
               m_fails++;
               if (m_fails == MF) begin
`ifdef LOCK_INPUT_ESCALATE_EN
                  m_left = LC * (1 << m_n);
                  if (m_n < 3) m_n++;
`else
                  m_left = LC;
`endif
                  locking = 1'b1;
               end
            end
         end
      end else begin
         m_left--;
         if (m_left == 0) m_fails = 0;
      end
      mask  = locked || locking;
      grant = '0;
      if (m_pend[0])               grant = 3'b001;
      else if (!mask && m_pend[1]) grant = 3'b010;
      else if (!mask && m_pend[2]) grant = 3'b100;
      m_out  = grant;
      m_pend = (m_pend & ~grant) | m_setq;
      if (mask) m_pend[2:1] = 2'b00;
      m_setq = '0;
      for (int b = 0; b < 3; b++) begin
         diff = 1'b1;
         for (int j = 2; j < D + 2; j++)
            if (raw_hist[j][b] == m_deb[b]) diff = 1'b0;
         if (diff) begin
            m_deb[b]  = ~m_deb[b];
            m_setq[b] = m_deb[b];
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_edge();
   end

   always @(negedge clk) begin
      if (scb_on && !rst)
         check("scb",
               {enter_p, clr_p, change_p, locked_out, fail_count},
               {m_out[1], m_out[0], m_out[2], (m_left > 0), 3'(m_fails)});
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      btn_enter    = 1'b0;
      btn_clr      = 1'b0;
      btn_change   = 1'b0;
      attempt_done = 1'b0;
      attempt_ok   = 1'b0;
      tick();
      check("rst_outputs",
            {enter_p, clr_p, change_p, locked_out, fail_count}, 0);
      tick();
      rst = 1'b0;
   endtask

   // edge index 0 = first posedge after the caller's last input change
   task automatic run_capture(input int n, output int ee, output int ce,
                              output int ge, output int ec, output int cc,
                              output int gc, output int ov);
      ee = -1; ce = -1; ge = -1;
      ec = 0;  cc = 0;  gc = 0; ov = 0;
      for (int c = 1; c <= n; c++) begin
         tick();
         if (enter_p)  begin ec++; if (ee < 0) ee = c - 1; end
         if (clr_p)    begin cc++; if (ce < 0) ce = c - 1; end
         if (change_p) begin gc++; if (ge < 0) ge = c - 1; end
         if (int'(enter_p) + int'(clr_p) + int'(change_p) > 1) ov++;
      end
   endtask

   task automatic measure_lock(output int len);
      attempt_ok = 1'b0;
      repeat (MF) begin
         attempt_done = 1'b1;
         tick();
      end
      attempt_done = 1'b0;
      len = 0;
      while (locked_out && len < 400) begin
         len++;
         tick();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ee, ce, ge, ec, cc, gc, ov, n, len;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd1};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'd1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd2};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 3'd3};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd3};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 3'd3};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'd3};
      for (int i = 7; i <= 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 3'd3};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 3'd1};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 3'd2};
      tbl[16] = '{1'b1, 1'b1, 1'b0, 3'd0};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 3'd1};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 3'd2};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 3'd2};

      tick();
      do_reset();
      scb_on = 1'b1;

      // bouncing enter, then a clean hold
      n = 0;
      for (int i = 0; i < 6; i++) begin
         btn_enter = (i % 2 == 0);
         tick();
         if (enter_p) n++;
      end
      check("bounce_none", n, 0);
      btn_enter = 1'b1;
      run_capture(12, ee, ce, ge, ec, cc, gc, ov);
      check("deb_count", ec, 1);
      check("deb_latency", ee, 7);
      btn_enter = 1'b0;
      run_capture(10, ee, ce, ge, ec, cc, gc, ov);
      check("release_none", ec, 0);
      btn_enter = 1'b1;
      run_capture(12, ee, ce, ge, ec, cc, gc, ov);
      check("repress_count", ec, 1);
      check("repress_latency", ee, 7);

      // simultaneous presses
      do_reset();
      btn_clr    = 1'b1;
      btn_enter  = 1'b1;
      btn_change = 1'b1;
      run_capture(14, ee, ce, ge, ec, cc, gc, ov);
      check("arb_clr_edge", ce, 7);
      check("arb_enter_edge", ee, 8);
      check("arb_change_edge", ge, 9);
      check("arb_counts", {cc[7:0], ec[7:0], gc[7:0]}, 24'h010101);
      check("arb_overlap", ov, 0);

      // failure counting, lockout length, success clear
      do_reset();
      for (int i = 0; i < 20; i++) begin
         attempt_done = tbl[i].done;
         attempt_ok   = tbl[i].ok;
         tick();
         check($sformatf("tbl%0d_lo", i), locked_out, tbl[i].lo);
         check($sformatf("tbl%0d_fc", i), fail_count, tbl[i].fc);
      end
      attempt_done = 1'b0;
      attempt_ok   = 1'b0;

      // presses during lockout: only clr gets through
      do_reset();
      attempt_done = 1'b1;
      tick();
      tick();
      btn_clr    = 1'b1;
      btn_enter  = 1'b1;
      btn_change = 1'b1;
      tick();
      check("lock_rise", locked_out, 1);
      attempt_done = 1'b0;
      run_capture(12, ee, ce, ge, ec, cc, gc, ov);
      check("lock_clr_count", cc, 1);
      check("lock_clr_edge", ce, 6);
      check("lock_enter_masked", ec, 0);
      check("lock_change_masked", gc, 0);
      btn_clr    = 1'b0;
      btn_enter  = 1'b0;
      btn_change = 1'b0;
      run_capture(10, ee, ce, ge, ec, cc, gc, ov);
      check("unlocked", {locked_out, fail_count}, 0);
      btn_enter = 1'b1;
      run_capture(12, ee, ce, ge, ec, cc, gc, ov);
      check("post_lock_enter", ec, 1);
      check("post_lock_latency", ee, 7);
      btn_enter = 1'b0;

      // reset in the middle of a lockout
      do_reset();
      attempt_done = 1'b1;
      repeat (MF) tick();
      attempt_done = 1'b0;
      repeat (4) tick();
      check("pre_rst_lock", {locked_out, fail_count}, 4'b1011);
      #2 rst = 1'b1;
      #1 check("rst_mid_lock", {locked_out, fail_count}, 0);
      tick();
      rst = 1'b0;

      // lockout durations back to back
      do_reset();
      measure_lock(len);
      check("lock_len1", len, LC);
`ifdef LOCK_INPUT_ESCALATE_EN
      measure_lock(len);
      check("lock_len2", len, LC * 2);
      measure_lock(len);
      check("lock_len3", len, LC * 4);
`endif

      // random stimulus against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) btn_clr    = ~btn_clr;
         if ($urandom_range(0, 9) == 0) btn_enter  = ~btn_enter;
         if ($urandom_range(0, 9) == 0) btn_change = ~btn_change;
         attempt_done = ($urandom_range(0, 11) == 0);
         attempt_ok   = ($urandom_range(0, 3) == 0);
         if (i == 2000) begin
            #2 rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         tick();
      end
      attempt_done = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
